pwm_sub: RTL and testbench

PWM_SUB -- requirements
Module: pwm_sub

---
 rtl/pwm_sub.sv | 74 +++++++
 tb/tb_pwm_sub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_sub.sv
// pwm_sub: 4-channel PWM compare stage against an external timer count, with register bus.
// Define PWM_SHADOW_UPDATE_EN for wrap-synchronised double-buffered duty updates.
module pwm_sub (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic [2:0]  addr,
    input  logic        ld,
    input  logic        oe,
    output logic [31:0] d_out,
    input  logic [31:0] count,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        pwm_c,
    output logic        pwm_d
);
`ifdef PWM_SHADOW_UPDATE_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    logic [31:0] shadow_q [4];
    logic [31:0] shadow_d [4];
    logic [31:0] active_q [4];
    logic [31:0] active_d [4];
    logic [31:0] count_q;
    logic [31:0] rd;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [3:0]  pend_q, pend_d, out_q, out_d;
    logic        wrap;
    always_comb begin
        wrap   = count < count_q;
        ctrl_d = (ld && addr == 3'd4) ? d_in[7:0] : ctrl_q;
        for (int n = 0; n < 4; n++) begin
            shadow_d[n] = (ld && addr == 3'(n)) ? d_in : shadow_q[n];
            // a write coinciding with wrap promotes the pre-write shadow and stays pending
            active_d[n] = SHADOW ? ((wrap && pend_q[n]) ? shadow_q[n] : active_q[n]) : shadow_d[n];
            pend_d[n]   = SHADOW & ((ld && addr == 3'(n)) | (pend_q[n] & ~wrap));
            out_d[n]    = (ctrl_d[n] & (count < active_d[n])) ^ ctrl_d[n+4];
        end
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                shadow_q[n] <= '0;
                active_q[n] <= '0;
            end
            count_q <= '0;
            ctrl_q  <= '0;
            pend_q  <= '0;
            out_q   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                shadow_q[n] <= shadow_d[n];
                active_q[n] <= active_d[n];
            end
            count_q <= count;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end
    always_comb begin
        rd = !addr[2]          ? shadow_q[addr[1:0]] :
             addr[1:0] == 2'd0 ? {24'h0, ctrl_q} :
             addr[1:0] == 2'd1 ? {28'h0, out_q} :
             addr[1:0] == 2'd2 ? {28'h0, pend_q} : 32'h0;
        d_out = oe ? rd : 32'h0;
    end
    assign pwm_a = out_q[0];
    assign pwm_b = out_q[1];
    assign pwm_c = out_q[2];
    assign pwm_d = out_q[3];
endmodule

// File: tb/tb_pwm_sub.sv
// tb_pwm_sub: directed vector table plus hand sequences for pwm_sub (both update modes).
module tb_pwm_sub;
`ifdef PWM_SHADOW_UPDATE_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif
    logic        clk_in = 1'b0;
    logic        reset, ld, oe;
    logic [31:0] d_in, count, d_out;
    logic [2:0]  addr;
    logic        pwm_a, pwm_b, pwm_c, pwm_d;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] c;
        logic        l;
        logic [2:0]  a;
        logic [31:0] d;
        logic        chk;
        logic [3:0]  e;
    } vec_t;
    vec_t vq[$];

    pwm_sub dut (
        .clk_in(clk_in), .reset(reset), .d_in(d_in), .addr(addr), .ld(ld), .oe(oe),
        .d_out(d_out), .count(count),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c), .pwm_d(pwm_d)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic [31:0] c, input logic l, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk_in);
        count = c; ld = l; addr = a; d_in = d;
        @(posedge clk_in);
        #1;
        ld = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic o, input logic [31:0] exp);
        addr = a; oe = o;
        #1;
        check(nm, d_out, exp);
        oe = 1'b0;
    endtask

    task automatic add(input logic [31:0] c, input logic l, input logic [2:0] a, input logic [31:0] d,
                       input logic chk, input logic [3:0] e);
        vq.push_back('{c, l, a, d, chk, e});
    endtask

    task automatic run_vecs();
        foreach (vq[i]) begin
            tick(vq[i].c, vq[i].l, vq[i].a, vq[i].d);
            if (vq[i].chk) check($sformatf("vec%0d cnt=%0d", i, vq[i].c), {28'h0, pwm_d, pwm_c, pwm_b, pwm_a}, {28'h0, vq[i].e});
        end
        vq.delete();
    endtask

    function automatic logic [3:0] pw();
        return {pwm_d, pwm_c, pwm_b, pwm_a};
    endfunction

    initial begin
        reset = 1'b1; ld = 1'b0; oe = 1'b0; addr = '0; d_in = '0; count = '0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b0;
        check("rst_pwm", {28'h0, pw()}, 32'h0);
        rd("rst_duty0", 0, 1, 32'h0);
        rd("rst_ctrl", 4, 1, 32'h0);
        rd("rst_pend", 6, 1, 32'h0);

        tick(0, 1, 4, 32'h1);
        tick(0, 1, 0, 32'h4);
        rd("pend_after_wr", 6, 1, SH ? 32'h1 : 32'h0);
        rd("duty0_rd", 0, 1, 32'h4);
        for (int c = 1; c <= 9; c++) add(c, 0, 0, 0, 0, 0);
        run_vecs();
        rd("pend_before_wrap", 6, 1, SH ? 32'h1 : 32'h0);
        add(0, 0, 0, 0, 1, 4'h1);
        run_vecs();
        rd("pend_after_wrap", 6, 1, 32'h0);

        for (int c = 1; c <= 9; c++) add(c, 0, 0, 0, 1, (c < 4) ? 4'h1 : 4'h0);
        add(0, 1, 4, 32'h11, 0, 0);
        for (int c = 1; c <= 9; c++) add(c, 0, 0, 0, 1, (c < 4) ? 4'h0 : 4'h1);
        add(0, 1, 4, 32'h10, 0, 0);
        add(2, 0, 0, 0, 1, 4'h1);
        add(5, 0, 0, 0, 1, 4'h1);
        add(7, 1, 4, 32'h6, 0, 0);
        add(8, 1, 1, 32'h0, 0, 0);
        add(9, 1, 2, 32'hFFFF_FFFF, 0, 0);
        add(0, 0, 0, 0, 1, 4'h4);
        add(5, 0, 0, 0, 1, 4'h4);
        add(32'hFFFF_FFFE, 0, 0, 0, 1, 4'h4);
        add(32'hFFFF_FFFF, 0, 0, 0, 1, 4'h0);
        add(3, 0, 0, 0, 1, 4'h4);
        add(0, 0, 0, 0, 1, 4'h4);
        run_vecs();

        tick(0, 1, 5, 32'hFFFF_FFFF);
        rd("status_ro", 5, 1, 32'h4);
        tick(0, 1, 7, 32'hFFFF_FFFF);
        rd("reserved", 7, 1, 32'h0);
        tick(0, 1, 4, 32'hFFFF_FF06);
        rd("ctrl_upper0", 4, 1, 32'h6);
        rd("rb_duty0", 0, 1, 32'h4);
        rd("rb_duty1", 1, 1, 32'h0);
        rd("rb_duty2", 2, 1, 32'hFFFF_FFFF);
        rd("rb_oe0", 2, 0, 32'h0);

        if (SH) begin
            tick(0, 1, 4, 32'h7);
            tick(5, 1, 0, 32'h6);
            check("sim_pre", {31'h0, pwm_a}, 32'h0);
            rd("sim_pend1", 6, 1, 32'h1);
            tick(0, 1, 0, 32'h8);
            rd("sim_pend_kept", 6, 1, 32'h1);
            rd("sim_shadow8", 0, 1, 32'h8);
            check("sim_act6_c0", {31'h0, pwm_a}, 32'h1);
            tick(5, 0, 0, 0);
            check("sim_act6_c5", {31'h0, pwm_a}, 32'h1);
            tick(6, 0, 0, 0);
            check("sim_act6_c6", {31'h0, pwm_a}, 32'h0);
            tick(0, 0, 0, 0);
            rd("sim_pend_clr", 6, 1, 32'h0);
            tick(7, 0, 0, 0);
            check("sim_act8_c7", {31'h0, pwm_a}, 32'h1);
            tick(7, 1, 0, 32'h8);
            rd("same_val_pend", 6, 1, 32'h1);
            tick(2, 0, 0, 0);
            rd("same_val_clr", 6, 1, 32'h0);
        end else begin
            tick(0, 1, 4, 32'h8);
            tick(2, 1, 3, 32'h5);
            tick(3, 0, 0, 0);
            check("dir_c3", {28'h0, pw()}, 32'h8);
            tick(4, 0, 0, 0);
            check("dir_c4", {28'h0, pw()}, 32'h8);
            tick(5, 0, 0, 0);
            check("dir_c5", {28'h0, pw()}, 32'h0);
            rd("dir_pend", 6, 1, 32'h0);
            rd("dir_duty3", 3, 1, 32'h5);
        end

        tick(0, 1, 4, 32'hF0);
        tick(1, 1, 0, 32'h3);
        tick(2, 1, 1, 32'h3);
        tick(3, 1, 2, 32'h3);
        tick(3, 1, 3, 32'h3);
        check("pre_rst_pwm", {28'h0, pw()}, 32'hF);
        rd("pre_rst_pend", 6, 1, SH ? 32'hF : 32'h0);
        reset = 1'b1;
        tick(3, 1, 4, 32'hFF);
        reset = 1'b0;
        check("mid_rst_pwm", {28'h0, pw()}, 32'h0);
        rd("mid_rst_pend", 6, 1, 32'h0);
        rd("mid_rst_ctrl", 4, 1, 32'h0);
        for (int n = 0; n < 4; n++) rd($sformatf("mid_rst_duty%0d", n), 3'(n), 1, 32'h0);

        tick(7, 1, 4, 32'h1);
        tick(8, 1, 0, 32'h2);
        tick(9, 0, 0, 0);
        rd("post_rst_nowrap", 6, 1, SH ? 32'h1 : 32'h0);
        check("post_rst_c9", {28'h0, pw()}, 32'h0);
        tick(1, 0, 0, 0);
        check("post_rst_c1", {28'h0, pw()}, 32'h1);
        rd("post_rst_pend", 6, 1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
